// File: rtl/exec_muldiv.sv
// exec_muldiv: iterative RV32M/RV64M multiply/divide unit that sits beside the
// slot-0 ALU. An op is accepted on start_i while idle. Signed operands are
// reduced to magnitudes, and the unsigned core then iterates: shift-add for
// multiply, restoring division for divide. The result sign is applied in the
// cycle the last iteration completes.
//
// Ports:
//   clk_i, rst_n_i     clock (rising edge), asynchronous active-low reset
//   flush_i            abort any in-flight op; result_o/rd_o are kept
//   start_i            op valid, sampled only while ready_o=1
//   funct3_i           RV M-extension funct3 (MUL..REMU)
//   rs1_i, rs2_i       operands A and B
//   rd_i               destination tag carried with the op
//   ready_o            high in IDLE only
//   stall_o            high while iterating (MUL or DIV state)
//   done_o             one-cycle completion pulse
//   result_o, rd_o     completed result and tag, held until the next completion
module exec_muldiv #(
   parameter int XLEN      = 32,
   parameter int MUL_BITS  = 1,
   parameter int DIV_BITS  = 1,
   parameter int EARLY_OUT = 1
) (
   input  logic            clk_i,
   input  logic            rst_n_i,
   input  logic            flush_i,
   input  logic            start_i,
   input  logic [2:0]      funct3_i,
   input  logic [XLEN-1:0] rs1_i,
   input  logic [XLEN-1:0] rs2_i,
   input  logic [4:0]      rd_i,
   output logic            ready_o,
   output logic            stall_o,
   output logic            done_o,
   output logic [XLEN-1:0] result_o,
   output logic [4:0]      rd_o
);

   localparam int MUL_ITERS = XLEN / MUL_BITS;
   localparam int DIV_ITERS = XLEN / DIV_BITS;
   localparam int CNT_W     = $clog2(XLEN + 1);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [2:0]        op_q, op_d;
   logic              sign_q, sign_d;
   logic [XLEN-1:0]   a_q, a_d;
   logic [2*XLEN-1:0] acc_q, acc_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [4:0]        rd_pend_q, rd_pend_d;
   logic [XLEN-1:0]   result_q, result_d;
   logic [4:0]        rd_q, rd_d;

   logic              a_neg, b_neg, is_div_in, is_rem_in, div_zero, div_ovf, early;
   logic [XLEN-1:0]   mag_a, mag_b, early_result;
   logic              in_sign;
   logic [XLEN+MUL_BITS-1:0] mul_hi;
   logic [2*XLEN-1:0] mul_next, prod_s, div_acc;
   logic [XLEN:0]     rem_t;
   logic [XLEN-1:0]   mul_res, div_res;

   // State and datapath registers
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q   <= S_IDLE;
         op_q      <= '0;
         sign_q    <= 1'b0;
         a_q       <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         rd_pend_q <= '0;
         result_q  <= '0;
         rd_q      <= '0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         sign_q    <= sign_d;
         a_q       <= a_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         rd_pend_q <= rd_pend_d;
         result_q  <= result_d;
         rd_q      <= rd_d;
      end
   end

   // Operand preparation at accept time. MUL takes both operands as unsigned
   // because the low half of the product does not depend on signedness. The
   // quotient sign is forced positive on divide-by-zero so that the full
   // iteration also produces all ones.
   always_comb begin
      is_div_in = funct3_i[2];
      is_rem_in = funct3_i[1];
      a_neg     = rs1_i[XLEN-1] & ((funct3_i == 3'b001) | (funct3_i == 3'b010) |
                                   (funct3_i == 3'b100) | (funct3_i == 3'b110));
      b_neg     = rs2_i[XLEN-1] & ((funct3_i == 3'b001) | (funct3_i == 3'b100) |
                                   (funct3_i == 3'b110));
      mag_a     = a_neg ? -rs1_i : rs1_i;
      mag_b     = b_neg ? -rs2_i : rs2_i;
      div_zero  = (rs2_i == '0);
      div_ovf   = ~funct3_i[0] & (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) & (rs2_i == '1);
      in_sign   = (is_div_in & is_rem_in) ? a_neg
                                          : ((a_neg ^ b_neg) & ~(is_div_in & div_zero));
      early     = (EARLY_OUT != 0) && is_div_in && (div_zero || div_ovf);
      if (div_zero) begin
         early_result = is_rem_in ? rs1_i : '1;
      end else begin
         early_result = is_rem_in ? '0 : rs1_i;
      end
   end

   // One iteration step of each engine, followed by sign fix-up of the value
   // that would be produced if this were the last iteration. The multiplier
   // consumes acc low bits while the partial product grows into the high
   // half. The divider shifts the dividend out of the low half into the
   // remainder and shifts quotient bits in behind it.
   always_comb begin
      mul_hi = {{MUL_BITS{1'b0}}, acc_q[2*XLEN-1:XLEN]};
      for (int i = 0; i < MUL_BITS; i++) begin
         if (acc_q[i]) begin
            mul_hi = mul_hi + ({{MUL_BITS{1'b0}}, a_q} << i);
         end
      end
      mul_next = {mul_hi, acc_q[XLEN-1:MUL_BITS]};
      prod_s   = sign_q ? -mul_next : mul_next;
      mul_res  = (op_q[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];

      div_acc = acc_q;
      rem_t   = '0;
      for (int j = 0; j < DIV_BITS; j++) begin
         rem_t = {div_acc[2*XLEN-1:XLEN], div_acc[XLEN-1]};
         div_acc[XLEN-1:0] = {div_acc[XLEN-2:0], 1'b0};
         if (rem_t >= {1'b0, a_q}) begin
            rem_t      = rem_t - {1'b0, a_q};
            div_acc[0] = 1'b1;
         end
         div_acc[2*XLEN-1:XLEN] = rem_t[XLEN-1:0];
      end
      if (op_q[1]) begin
         div_res = sign_q ? -div_acc[2*XLEN-1:XLEN] : div_acc[2*XLEN-1:XLEN];
      end else begin
         div_res = sign_q ? -div_acc[XLEN-1:0] : div_acc[XLEN-1:0];
      end
   end

   // Next-state logic. result/rd are written only on the edge that enters
   // DONE. Flush overrides everything, including that write.
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      sign_d    = sign_q;
      a_d       = a_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      rd_pend_d = rd_pend_q;
      result_d  = result_q;
      rd_d      = rd_q;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               op_d      = funct3_i;
               sign_d    = in_sign;
               rd_pend_d = rd_i;
               cnt_d     = '0;
               a_d       = is_div_in ? mag_b : mag_a;
               acc_d     = {{XLEN{1'b0}}, (is_div_in ? mag_a : mag_b)};
               if (early) begin
                  state_d  = S_DONE;
                  result_d = early_result;
                  rd_d     = rd_i;
               end else begin
                  state_d = is_div_in ? S_DIV : S_MUL;
               end
            end
         end
         S_MUL: begin
            acc_d = mul_next;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(MUL_ITERS - 1)) begin
               state_d  = S_DONE;
               result_d = mul_res;
               rd_d     = rd_pend_q;
            end
         end
         S_DIV: begin
            acc_d = div_acc;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(DIV_ITERS - 1)) begin
               state_d  = S_DONE;
               result_d = div_res;
               rd_d     = rd_pend_q;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (flush_i) begin
         state_d  = S_IDLE;
         result_d = result_q;
         rd_d     = rd_q;
      end
   end

   // Outputs are decoded from the current state only
   always_comb begin
      ready_o  = (state_q == S_IDLE);
      stall_o  = (state_q == S_MUL) || (state_q == S_DIV);
      done_o   = (state_q == S_DONE);
      result_o = result_q;
      rd_o     = rd_q;
   end

endmodule
